// File: rtl/coupled_counter_pair.sv
// ============================================================================
// coupled_counter_pair
// ----------------------------------------------------------------------------
// Two cross-coupled WIDTH-bit counters that move in lock-step so that
// cnt_a + cnt_b (mod 2**WIDTH) never changes between a reset/clear and a load.
// The pair can be loaded, cleared and run in one of four update modes. It
// reports 1-cycle terminal-count pulses when a counter update carries or
// borrows out of WIDTH bits, and keeps a saturating count of tc_a pulses.
//
// Parameters
//   WIDTH   counter width in bits (>= 2)
//   STEP    per-cycle increment/decrement, 1 <= STEP < 2**WIDTH
//   WRAP_W  width of wrap_cnt
//
// Ports
//   clk       in   1       rising-edge clock
//   rst_n     in   1       asynchronous active-low reset
//   clr       in   1       synchronous clear (highest synchronous priority)
//   load      in   1       load cnt_a <= load_val, cnt_b <= ~load_val
//   load_val  in   WIDTH   value to load
//   en        in   1       run enable
//   mode      in   2       00 UP, 01 DOWN, 10 CROSS, 11 HOLD
//   cnt_a     out  WIDTH   counter A
//   cnt_b     out  WIDTH   counter B
//   tc_a      out  1       pulse: last cnt_a update carried/borrowed out
//   tc_b      out  1       pulse: last cnt_b update carried/borrowed out
//   wrap_cnt  out  WRAP_W  number of tc_a pulses, saturating at all-ones
//   busy      out  1       controller is not IDLE
//
// Build option
//   FORMAL_CHECKS_EN  when defined, adds a shadow register holding the
//                     expected cnt_a+cnt_b and concurrent assertions on the
//                     sum invariant, the origin of tc_a and the monotonicity
//                     of wrap_cnt. Ports and behaviour are unchanged.
// ============================================================================
module coupled_counter_pair #(
    parameter int WIDTH  = 4,
    parameter int STEP   = 1,
    parameter int WRAP_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              en,
    input  logic [1:0]        mode,
    output logic [WIDTH-1:0]  cnt_a,
    output logic [WIDTH-1:0]  cnt_b,
    output logic              tc_a,
    output logic              tc_b,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    localparam logic [1:0] MODE_UP    = 2'b00;
    localparam logic [1:0] MODE_DOWN  = 2'b01;
    localparam logic [1:0] MODE_CROSS = 2'b10;
    localparam logic [1:0] MODE_HOLD  = 2'b11;

    // Step widened by one bit so bit WIDTH of each lane result is the
    // carry (on add) or borrow (on subtract).
    localparam logic [WIDTH:0]    STEP_EXT = STEP[WIDTH:0];
    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t             state_reg;
    state_t             state_next;
    logic [WIDTH-1:0]   cnt_a_reg;
    logic [WIDTH-1:0]   cnt_b_reg;
    logic               tc_a_reg;
    logic               tc_b_reg;
    logic [WRAP_W-1:0]  wrap_cnt_reg;

    // Asserted on cycles where the counters actually take a new value.
    logic               run_update;

    // Per-lane arithmetic results (lane 0 = A, lane 1 = B).
    logic [1:0][WIDTH-1:0] lane_val;
    logic [1:0]            lane_carry;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic. clr and load override the normal transitions
    // from any state.
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        if (clr) begin
            state_next = ST_IDLE;
        end else if (load) begin
            state_next = ST_LOAD;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (en) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        state_next = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    state_next = en ? ST_RUN : ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM: outputs. Dropping en in RUN leaves the counters untouched on that
    // same edge, so the update strobe also requires en. HOLD is treated as
    // "no update", which also forces both tc pulses low.
    // ------------------------------------------------------------------------
    always_comb begin
        busy       = (state_reg != ST_IDLE);
        run_update = (state_reg == ST_RUN) && en && !clr && !load
                     && (mode != MODE_HOLD);
    end

    // ------------------------------------------------------------------------
    // Update lanes. Each lane picks a source counter and a direction from the
    // mode, then adds or subtracts STEP in WIDTH+1 bits. Because lane A and
    // lane B always move in opposite directions by the same STEP (CROSS
    // swaps the sources but keeps the pairing), the sum is preserved.
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            localparam bit IS_A = (gi == 0);

            logic [WIDTH-1:0] lane_base;
            logic             lane_add;
            logic [WIDTH:0]   lane_ext;

            always_comb begin
                lane_base = IS_A ? cnt_a_reg : cnt_b_reg;
                lane_add  = IS_A;
                case (mode)
                    MODE_UP: begin
                        lane_add = IS_A;
                    end
                    MODE_DOWN: begin
                        lane_add = !IS_A;
                    end
                    MODE_CROSS: begin
                        // Both lanes read the other counter's pre-update value.
                        lane_base = IS_A ? cnt_b_reg : cnt_a_reg;
                        lane_add  = IS_A;
                    end
                    default: begin
                        lane_add = IS_A;
                    end
                endcase
                lane_ext = lane_add ? ({1'b0, lane_base} + STEP_EXT)
                                    : ({1'b0, lane_base} - STEP_EXT);
            end

            assign lane_val[gi]   = lane_ext[WIDTH-1:0];
            assign lane_carry[gi] = lane_ext[WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a_reg    <= '0;
            cnt_b_reg    <= '0;
            tc_a_reg     <= 1'b0;
            tc_b_reg     <= 1'b0;
            wrap_cnt_reg <= '0;
        end else if (clr) begin
            cnt_a_reg    <= '0;
            cnt_b_reg    <= '0;
            tc_a_reg     <= 1'b0;
            tc_b_reg     <= 1'b0;
            wrap_cnt_reg <= '0;
        end else if (load) begin
            // ~load_val makes the pair sum all-ones right after a load.
            cnt_a_reg <= load_val;
            cnt_b_reg <= ~load_val;
            tc_a_reg  <= 1'b0;
            tc_b_reg  <= 1'b0;
        end else if (run_update) begin
            cnt_a_reg <= lane_val[0];
            cnt_b_reg <= lane_val[1];
            tc_a_reg  <= lane_carry[0];
            tc_b_reg  <= lane_carry[1];
            // Counted on the same edge that raises tc_a, so every pulse
            // (including back-to-back ones) is counted exactly once.
            if (lane_carry[0] && (wrap_cnt_reg != WRAP_MAX)) begin
                wrap_cnt_reg <= wrap_cnt_reg + 1'b1;
            end
        end else begin
            tc_a_reg <= 1'b0;
            tc_b_reg <= 1'b0;
        end
    end

    assign cnt_a    = cnt_a_reg;
    assign cnt_b    = cnt_b_reg;
    assign tc_a     = tc_a_reg;
    assign tc_b     = tc_b_reg;
    assign wrap_cnt = wrap_cnt_reg;

`ifdef FORMAL_CHECKS_EN
    // ------------------------------------------------------------------------
    // Invariant checking: inv_sum tracks what cnt_a+cnt_b must equal.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] inv_sum_reg;
    logic [WIDTH-1:0] pair_sum;

    assign pair_sum = cnt_a_reg + cnt_b_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_sum_reg <= '0;
        end else if (clr) begin
            inv_sum_reg <= '0;
        end else if (load) begin
            inv_sum_reg <= '1;
        end
    end

    a_sum_invariant : assert property (
        @(posedge clk) disable iff (!rst_n)
        pair_sum == inv_sum_reg
    );

    a_tc_a_from_run : assert property (
        @(posedge clk) disable iff (!rst_n)
        tc_a_reg |-> ($past(state_reg) == ST_RUN)
    );

    a_wrap_monotonic : assert property (
        @(posedge clk) disable iff (!rst_n)
        (wrap_cnt_reg < $past(wrap_cnt_reg)) |-> $past(clr)
    );
`endif

endmodule
